// File: rtl/vram_bg_fetcher_if.sv
// rtl/vram_bg_fetcher_if.sv - VRAM read port and pixel output stream of the background fetcher
interface vram_bg_fetcher_if;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_q;
  logic [1:0]  pix;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output vram_addr, vram_rd, pix, pix_valid,
    input  vram_q, pix_ready
  );

  modport slave (
    input  vram_addr, vram_rd, pix, pix_valid,
    output vram_q, pix_ready
  );
endinterface

// File: rtl/vram_bg_fetcher.sv
// rtl/vram_bg_fetcher.sv - fetches one 160-pixel background scanline from VRAM into a pixel FIFO
module vram_bg_fetcher (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        line_y,
  input  logic [7:0]        scx,
  input  logic              map_sel,
  input  logic              tile_sel,
  output logic              busy,
  vram_bg_fetcher_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH
  } state_t;

  state_t      state, state_nxt;

  // Line parameters captured when a fetch is accepted
  logic [7:0]  ly_q;
  logic [4:0]  sx_q;
  logic        map_sel_q;
  logic        tile_sel_q;

  // Tile counter and per-tile fetched bytes
  logic [4:0]  n;
  logic [7:0]  tile_idx;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [12:0] addr_hold;

  // Pixel FIFO: 16 x 2-bit ring buffer
  logic [1:0]  fifo_mem [16];
  logic [1:0]  push_pix [8];
  logic [3:0]  rd_ptr;
  logic [3:0]  wr_ptr;
  logic [4:0]  count;

  logic        accept;
  logic        push;
  logic        pop;
  logic        is_a;
  logic [4:0]  tx;
  logic [12:0] map_addr;
  logic [12:0] lo_addr;
  logic [12:0] cur_addr;

  // Only the coarse scroll (whole tiles) matters to the fetcher
  logic        unused_scx_lo;
  assign unused_scx_lo = ^scx[2:0];

  assign busy   = (state != IDLE) || (count != 5'd0);
  assign accept = (state == IDLE) && !busy && start;
  assign push   = (state == PUSH) && (count <= 5'd8);
  assign pop    = bus.pix_valid && bus.pix_ready;

  // 5-bit add wraps the tile column without touching the row field
  assign tx       = sx_q + n;
  assign map_addr = (map_sel_q ? 13'h1C00 : 13'h1800) + {3'b000, ly_q[7:3], tx};
  assign lo_addr  = tile_sel_q
                  ? {1'b0, tile_idx, 4'b0000} + {9'd0, ly_q[2:0], 1'b0}
                  : 13'h1000 + {tile_idx[7], tile_idx, 4'b0000} + {9'd0, ly_q[2:0], 1'b0};

  assign bus.vram_rd   = is_a;
  assign bus.vram_addr = cur_addr;
  assign bus.pix_valid = (count != 5'd0);
  assign bus.pix       = (count != 5'd0) ? fifo_mem[rd_ptr] : 2'b00;

  // Pixel order within a tile: leftmost pixel is bit 7 of each plane
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      push_pix[i] = {hi_q[3'(7 - i)], lo_q[3'(7 - i)]};
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and VRAM strobe/address; address holds outside *_A states
  always_comb begin
    state_nxt = state;
    is_a      = 1'b0;
    cur_addr  = addr_hold;
    case (state)
      IDLE:  if (accept) state_nxt = MAP_A;
      MAP_A: begin
        is_a      = 1'b1;
        cur_addr  = map_addr;
        state_nxt = MAP_D;
      end
      MAP_D: state_nxt = LO_A;
      LO_A: begin
        is_a      = 1'b1;
        cur_addr  = lo_addr;
        state_nxt = LO_D;
      end
      LO_D:  state_nxt = HI_A;
      HI_A: begin
        is_a      = 1'b1;
        cur_addr  = {lo_addr[12:1], 1'b1};
        state_nxt = HI_D;
      end
      HI_D:  state_nxt = PUSH;
      PUSH:  if (push) state_nxt = (n < 5'd19) ? MAP_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line parameters, tile counter and captured VRAM bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      ly_q       <= 8'd0;
      sx_q       <= 5'd0;
      map_sel_q  <= 1'b0;
      tile_sel_q <= 1'b0;
      n          <= 5'd0;
      tile_idx   <= 8'd0;
      lo_q       <= 8'd0;
      hi_q       <= 8'd0;
      addr_hold  <= 13'd0;
    end else begin
      if (accept) begin
        ly_q       <= line_y;
        sx_q       <= scx[7:3];
        map_sel_q  <= map_sel;
        tile_sel_q <= tile_sel;
        n          <= 5'd0;
      end
      if (is_a) addr_hold <= cur_addr;
      if (state == MAP_D) tile_idx <= bus.vram_q;
      if (state == LO_D)  lo_q     <= bus.vram_q;
      if (state == HI_D)  hi_q     <= bus.vram_q;
      if (push) n <= n + 5'd1;
    end
  end

  // FIFO pointers and occupancy; push of 8 and pop of 1 may coincide
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 4'd0;
      wr_ptr <= 4'd0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd8;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      count <= count + (push ? 5'd8 : 5'd0) - (pop ? 5'd1 : 5'd0);
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        fifo_mem[wr_ptr + 4'(i)] <= push_pix[i];
      end
    end
  end

endmodule

// File: tb/tb_vram_bg_fetcher.sv
// tb/tb_vram_bg_fetcher.sv - directed self-checking bench for vram_bg_fetcher
module tb_vram_bg_fetcher;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] line_y;
  logic [7:0] scx;
  logic       map_sel;
  logic       tile_sel;
  logic       busy;

  vram_bg_fetcher_if bus ();

  vram_bg_fetcher dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .line_y   (line_y),
    .scx      (scx),
    .map_sel  (map_sel),
    .tile_sel (tile_sel),
    .busy     (busy),
    .bus      (bus)
  );

  logic [7:0] vmem [8192];
  int         rd_addr [$];
  int         rd_cyc [$];
  int         pix_log [$];
  int         exp_map [$];
  int         exp_pix [$];
  int         cyc;
  int         n_checks;
  int         n_pass;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // VRAM model with one-cycle read latency
  always @(posedge clock) begin
    if (bus.vram_rd) bus.vram_q <= vmem[bus.vram_addr];
  end

  // Log read strobes and popped pixels
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.vram_rd) begin
      rd_addr.push_back(int'(bus.vram_addr));
      rd_cyc.push_back(cyc);
    end
    if (bus.pix_valid && bus.pix_ready) pix_log.push_back(int'(bus.pix));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    rd_cyc.delete();
    pix_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic start_line(input logic [7:0] ly, input logic [7:0] sx, input logic ms, input logic ts);
    line_y   = ly;
    scx      = sx;
    map_sel  = ms;
    tile_sel = ts;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Reference line built straight from the tile-map/tile-data definitions
  task automatic build_expect(input logic [7:0] ly, input logic [7:0] sx, input logic ms, input logic ts);
    exp_map.delete();
    exp_pix.delete();
    for (int t = 0; t < 20; t++) begin
      int tx;
      int ma;
      int idx;
      int sidx;
      int la;
      int lo;
      int hi;
      tx  = ((int'(sx) / 8) + t) % 32;
      ma  = (ms ? 'h1C00 : 'h1800) + (int'(ly) / 8) * 32 + tx;
      idx = int'(vmem[ma]);
      if (ts) la = idx * 16 + (int'(ly) % 8) * 2;
      else begin
        sidx = (idx >= 128) ? idx - 256 : idx;
        la   = ('h1000 + sidx * 16 + (int'(ly) % 8) * 2) & 'h1FFF;
      end
      lo = int'(vmem[la]);
      hi = int'(vmem[la + 1]);
      exp_map.push_back(ma);
      for (int i = 0; i < 8; i++) begin
        exp_pix.push_back(((hi >> (7 - i)) & 1) * 2 + ((lo >> (7 - i)) & 1));
      end
    end
  endtask

  task automatic compare_line(input string tag);
    int bad_map;
    int bad_pix;
    bad_map = 0;
    bad_pix = 0;
    check_eq({tag, "_reads"}, rd_addr.size(), 32'd60);
    check_eq({tag, "_pixels"}, pix_log.size(), 32'd160);
    for (int t = 0; t < 20; t++) begin
      if (3 * t >= rd_addr.size() || rd_addr[3 * t] != exp_map[t]) bad_map++;
    end
    for (int p = 0; p < 160; p++) begin
      if (p >= pix_log.size() || pix_log[p] != exp_pix[p]) bad_pix++;
    end
    check_eq({tag, "_map_bad"}, bad_map, 32'd0);
    check_eq({tag, "_pix_bad"}, bad_pix, 32'd0);
  endtask

  initial begin
    int k;
    int pat [8];
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    line_y   = 8'd0;
    scx      = 8'd0;
    map_sel  = 1'b0;
    tile_sel = 1'b1;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 8192; i++) vmem[i] = 8'd0;
    repeat (3) @(negedge clock);

    // Reset state
    check_eq("rst_vram_rd", {31'd0, bus.vram_rd}, 32'd0);
    check_eq("rst_vram_addr", {19'd0, bus.vram_addr}, 32'd0);
    check_eq("rst_pix", {30'd0, bus.pix}, 32'd0);
    check_eq("rst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    // Map read, unsigned tile, pixel order; start on first cycle out of reset
    vmem['h1800] = 8'h05;
    vmem['h0050] = 8'hF0;
    vmem['h0051] = 8'hCC;
    bus.pix_ready = 1'b1;
    clear_logs();
    reset = 1'b0;
    start_line(8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("first_map_rd", {31'd0, bus.vram_rd}, 32'd1);
    check_eq("first_map_addr", {19'd0, bus.vram_addr}, 32'h1800);
    @(negedge clock);
    check_eq("map_d_rd_low", {31'd0, bus.vram_rd}, 32'd0);
    check_eq("map_d_addr_hold", {19'd0, bus.vram_addr}, 32'h1800);
    wait_idle("a", 2000);
    check_eq("a_lo_addr", rd_addr[1], 32'h0050);
    check_eq("a_hi_addr", rd_addr[2], 32'h0051);
    check_eq("a_map1_addr", rd_addr[3], 32'h1801);
    check_eq("a_tile_cycles", rd_cyc[3] - rd_cyc[0], 32'd7);
    pat = '{3, 3, 1, 1, 2, 2, 0, 0};
    for (int i = 0; i < 8; i++) check_eq($sformatf("a_pix%0d", i), pix_log[i], pat[i]);
    build_expect(8'h00, 8'h00, 1'b0, 1'b1);
    compare_line("a");

    // Signed tile data addressing
    do_reset();
    vmem['h1800] = 8'h80;
    vmem['h1801] = 8'h7F;
    start_line(8'h03, 8'h00, 1'b0, 1'b0);
    wait_idle("b", 2000);
    check_eq("b_lo_80", rd_addr[1], 32'h0806);
    check_eq("b_hi_80", rd_addr[2], 32'h0807);
    check_eq("b_lo_7f", rd_addr[4], 32'h17F6);
    check_eq("b_hi_7f", rd_addr[5], 32'h17F7);

    // Horizontal wrap within the map row
    do_reset();
    start_line(8'h10, 8'hF8, 1'b1, 1'b1);
    wait_idle("c", 2000);
    check_eq("c_map0", rd_addr[0], 32'h1C5F);
    check_eq("c_map1", rd_addr[3], 32'h1C40);
    check_eq("c_map2", rd_addr[6], 32'h1C41);
    build_expect(8'h10, 8'hF8, 1'b1, 1'b1);
    compare_line("c");

    // Backpressure: distinct tiles, consumer stalled then released
    for (int t = 0; t < 32; t++) begin
      vmem['h1800 + t] = 8'(t + 1);
      vmem[(t + 1) * 16 + 10] = 8'(((t + 1) * 37 + 'h5A) & 'hFF);
      vmem[(t + 1) * 16 + 11] = 8'(((t + 1) * 113 + 7) & 'hFF);
    end
    do_reset();
    bus.pix_ready = 1'b0;
    build_expect(8'h05, 8'h10, 1'b0, 1'b1);
    start_line(8'h05, 8'h10, 1'b0, 1'b1);
    repeat (100) @(negedge clock);
    check_eq("bp_stall_reads", rd_addr.size(), 32'd9);
    check_eq("bp_pix_valid", {31'd0, bus.pix_valid}, 32'd1);
    check_eq("bp_busy", {31'd0, busy}, 32'd1);
    check_eq("bp_head_pix", {30'd0, bus.pix}, exp_pix[0]);
    check_eq("bp_no_pops", pix_log.size(), 32'd0);
    bus.pix_ready = 1'b1;
    wait_idle("bp", 3000);
    compare_line("bp");

    // Reset while in HI_D of the second tile
    do_reset();
    bus.pix_ready = 1'b0;
    start_line(8'h05, 8'h10, 1'b0, 1'b1);
    k = 0;
    while (rd_addr.size() < 6 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check_eq("e_reach_hi_d", rd_addr.size(), 32'd6);
    check_eq("e_fifo_filled", {31'd0, bus.pix_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("e_busy", {31'd0, busy}, 32'd0);
    check_eq("e_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
    check_eq("e_vram_rd", {31'd0, bus.vram_rd}, 32'd0);
    check_eq("e_vram_addr", {19'd0, bus.vram_addr}, 32'd0);
    check_eq("e_pix", {30'd0, bus.pix}, 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("e_no_more_reads", rd_addr.size(), 32'd6);

    // Start pulse while busy is ignored
    clear_logs();
    bus.pix_ready = 1'b1;
    build_expect(8'h05, 8'h10, 1'b0, 1'b1);
    start_line(8'h05, 8'h10, 1'b0, 1'b1);
    repeat (10) @(negedge clock);
    start_line(8'h40, 8'h00, 1'b1, 1'b0);
    wait_idle("r", 3000);
    compare_line("r");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_bg_fetcher.md
VRAM_BG_FETCHER -- requirements
Module: vram_bg_fetcher

Interface
REQ-001 The block SHALL have these ports: clock, in, 1, system clock; all logic on rising edge.
REQ-002 reset, in, 1, synchronous active-high reset.
REQ-003 start, in, 1, single-cycle pulse that begins one scanline fetch.
REQ-004 line_y, in, 8, background row (scanline + SCY, mod 256), sampled on accepted start.
REQ-005 scx, in, 8, horizontal scroll; only scx[7:3] is used, sampled on accepted start.
REQ-006 map_sel, in, 1, tile map base: 0 -> 0x1800, 1 -> 0x1C00 (13-bit VRAM addresses), sampled on accepted start.
REQ-007 tile_sel, in, 1, tile data mode: 1 -> unsigned base 0x0000, 0 -> signed base 0x1000, sampled on accepted start.
REQ-008 vram_addr, out, 13, VRAM read address.
REQ-009 vram_rd, out, 1, read strobe; vram_q is valid on the cycle after vram_rd is high.
REQ-010 vram_q, in, 8, VRAM read data (1-cycle synchronous read latency).
REQ-011 pix, out, 2, colour index {hi bit, lo bit} of the FIFO head.
REQ-012 pix_valid, out, 1, FIFO non-empty.
REQ-013 pix_ready, in, 1, consumer accepts pix; a pop occurs on pix_valid & pix_ready.
REQ-014 busy, out, 1, high while state != IDLE or FIFO non-empty.

Function
REQ-015 The state machine SHALL use these states: IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH.
REQ-016 In IDLE, start with busy=0 SHALL latch the inputs, clear tile counter n to 0, and go to MAP_A; start with busy=1 SHALL be ignored.
REQ-017 In every *_A state, vram_rd SHALL be 1 for exactly one cycle with the state's address; in every *_D state, the block SHALL capture vram_q, and vram_rd SHALL be 0.
REQ-018 In any state other than *_A, vram_rd SHALL be 0, and vram_addr SHALL hold its last value.
REQ-019 The map address SHALL be map_base + {line_y[7:3], tx[4:0]}, where tx = (scx[7:3] + n) mod 32; the x coordinate wraps at 32 tiles without a carry into the y field.
REQ-020 Unsigned mode: the LO address SHALL be tile_idx*16 + line_y[2:0]*2.
REQ-021 Signed mode: the LO address SHALL be 0x1000 + sext(tile_idx)*16 + line_y[2:0]*2, computed modulo 2^13.
REQ-022 The HI address SHALL be the LO address + 1.
REQ-023 In PUSH, if the FIFO free count is >= 8, the block SHALL write 8 pixels in one cycle, ordered i=0..7 as {hi[7-i], lo[7-i]}, and then increment n.
REQ-024 In PUSH, if the FIFO free count is < 8, the block SHALL stall in PUSH.
REQ-025 After PUSH, the block SHALL go to MAP_A if n < 20; otherwise it SHALL go to IDLE (160 pixels per line).
REQ-026 Each tile SHALL take exactly 7 cycles (MAP_A through PUSH) when the block is not stalled.
REQ-027 The FIFO SHALL hold 16 entries of 2 bits, with a 5-bit count.
REQ-028 The FIFO SHALL support a simultaneous push and pop in the same cycle, with count = count + 8 - 1.
REQ-029 Popping when empty SHALL have no effect, and pix SHALL be 0 when the FIFO is empty.
REQ-030 pix_valid SHALL depend only on registered FIFO state, with no combinational path from pix_ready.

Reset
REQ-031 While reset is high, state SHALL be IDLE, n = 0, and the FIFO SHALL be emptied.
REQ-032 While reset is high, vram_rd, vram_addr, pix, pix_valid, and busy SHALL all be 0.
REQ-033 Reset asserted mid-fetch SHALL abort the line on the next edge, with no further VRAM reads.
REQ-034 The first start is accepted on the cycle after reset is deasserted.

Verification
REQ-035 Map read: map_sel=0, scx=0, line_y=0, start -> vram_addr 0x1800 at MAP_A; vram_q=0x05 -> LO addr 0x0050 and HI addr 0x0051, unsigned mode.
REQ-036 Signed tiles: tile_sel=0, line_y=3, tile_idx=0x80 -> LO addr 0x0806; tile_idx=0x7F -> LO addr 0x17F6.
REQ-037 Wrap: scx=0xF8, map_sel=1, line_y=0x10 -> map addresses in order 0x1C5F, 0x1C40, 0x1C41, ...
REQ-038 Pixels: lo=0xF0, hi=0xCC, pix_ready=1 -> pix sequence 3,3,1,1,2,2,0,0.
REQ-039 Backpressure: pix_ready=0 for a full line -> FIFO fills to 16 after 2 tiles, the block stalls in PUSH, and there are no extra vram_rd pulses. When pix_ready=1, all 160 pixels are delivered in order, then busy falls.
REQ-040 Reset during HI_D -> the next cycle has state IDLE, pix_valid=0, and busy=0; a start pulse during busy produces no restart.
